// File: rtl/mini_core_pkg.sv
// Shared types and constants for the mini core execute stage.
package mini_core_pkg;

  localparam int MD_ITERS = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_IN2  = 4'd10
  } t_alu_op;

  // Encoded as RV32M funct3; bit 2 set means a divide-class op.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } t_muldiv_op;

  typedef struct packed {
    logic       ValidQ102H;
    t_alu_op    AluOpQ102H;
    logic       SelImmQ102H;
    logic       SelPcQ102H;
    logic       MulDivEnQ102H;
    t_muldiv_op MulDivOpQ102H;
  } t_ctrl_exe;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } t_md_state;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mini_core_exe_if.sv
// Q102H inputs and Q103H outputs of the execute stage.
interface mini_core_exe_if;

  mini_core_pkg::t_ctrl_exe Ctrl;
  logic        FlushQ102H;
  logic [31:0] PcQ102H;
  logic [31:0] ImmediateQ102H;
  logic [31:0] RegRdData1Q102H;
  logic [31:0] RegRdData2Q102H;
  logic        ReadyQ102H;
  logic        ValidQ103H;
  logic [31:0] AluOutQ103H;
  logic [31:0] RegRdData2Q103H;
  logic [31:0] PcQ103H;

  // Decode/register-file side
  modport master (
    output Ctrl, FlushQ102H, PcQ102H, ImmediateQ102H, RegRdData1Q102H, RegRdData2Q102H,
    input  ReadyQ102H, ValidQ103H, AluOutQ103H, RegRdData2Q103H, PcQ103H
  );

  // Execute stage side
  modport slave (
    input  Ctrl, FlushQ102H, PcQ102H, ImmediateQ102H, RegRdData1Q102H, RegRdData2Q102H,
    output ReadyQ102H, ValidQ103H, AluOutQ103H, RegRdData2Q103H, PcQ103H
  );

endinterface

// File: rtl/mini_core_muldiv.sv
// Iterative RV32M unit: shift-add multiply, restoring divide, 32 iterations,
// sign fix-up in the DONE cycle. Rst is synchronous active-low.
module mini_core_muldiv
  import mini_core_pkg::*;
(
  input  logic        Clock,
  input  logic        Rst,
  input  logic        start,
  input  logic        flush,
  input  t_muldiv_op  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  t_md_state   state, state_next;
  logic [4:0]  iter_cnt, iter_cnt_next;
  logic [63:0] acc;
  logic [31:0] opnd;
  t_muldiv_op  op_q;
  logic        neg_res, neg_rem, div_zero;

  logic        fire;
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] add_sum, sub_trial, sub_diff;
  logic [63:0] acc_step, prod;

  assign fire = start & (state == IDLE) & ~flush & Rst;
  assign busy = (state == BUSY) | fire;
  assign done = (state == DONE);

  assign a_neg = a_signed & a[31];
  assign b_neg = b_signed & b[31];
  assign a_mag = neg_if(a_neg, a);
  assign b_mag = neg_if(b_neg, b);

  // Which operands are treated as signed for the incoming op
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      MD_MULH, MD_DIV, MD_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      MD_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
  end

  // One multiply or divide iteration on the accumulator
  always_comb begin
    add_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    sub_trial = acc[63:31];
    sub_diff  = sub_trial - {1'b0, opnd};
    if (op_q[2]) begin
      if (!sub_diff[32]) acc_step = {sub_diff[31:0], acc[30:0], 1'b1};
      else               acc_step = {sub_trial[31:0], acc[30:0], 1'b0};
    end else begin
      acc_step = {add_sum, acc[31:1]};
    end
  end

  // Sign fix-up and result select; divide by zero forces an all-ones quotient
  always_comb begin
    prod   = neg_res ? (~acc + 64'd1) : acc;
    result = 32'd0;
    case (op_q)
      MD_MUL:                        result = prod[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  result = prod[63:32];
      MD_DIV, MD_DIVU:               result = div_zero ? 32'hFFFF_FFFF : neg_if(neg_res, acc[31:0]);
      MD_REM, MD_REMU:               result = neg_if(neg_rem, acc[63:32]);
      default:                       result = 32'd0;
    endcase
  end

  // FSM state and iteration counter registers
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      state    <= IDLE;
      iter_cnt <= 5'd0;
    end else begin
      state    <= state_next;
      iter_cnt <= iter_cnt_next;
    end
  end

  // Next state: IDLE -> BUSY for 32 iterations -> DONE -> IDLE; flush aborts
  always_comb begin
    state_next    = state;
    iter_cnt_next = iter_cnt;
    case (state)
      IDLE: begin
        if (fire) begin
          state_next    = BUSY;
          iter_cnt_next = 5'd0;
        end
      end
      BUSY: begin
        iter_cnt_next = iter_cnt + 5'd1;
        if (iter_cnt == 5'(MD_ITERS - 1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Operand capture on start, accumulator update while busy
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      acc      <= 64'd0;
      opnd     <= 32'd0;
      op_q     <= MD_MUL;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (fire) begin
      op_q     <= op;
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= (b == 32'd0);
      if (op[2]) begin
        acc  <= {32'd0, a_mag};
        opnd <= b_mag;
      end else begin
        acc  <= {32'd0, b_mag};
        opnd <= a_mag;
      end
    end else if (state == BUSY) begin
      acc <= acc_step;
    end
  end

endmodule

// File: rtl/mini_core_exe.sv
// Q102H->Q103H execute stage: single-cycle ALU plus optional iterative RV32M
// unit that stalls upstream through ReadyQ102H. Rst is synchronous active-low.
module mini_core_exe
  import mini_core_pkg::*;
#(
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic           Clock,
  input  logic           Rst,
  mini_core_exe_if.slave exe
);

  t_ctrl_exe   ctrl;
  logic [31:0] in1, in2;
  logic [4:0]  shamt;
  logic [31:0] alu_out, exe_result;
  logic        md_req, md_busy, md_done;
  logic [31:0] md_result;
  logic        ready;

  logic        valid_q;
  logic [31:0] alu_out_q, rs2_q, pc_q;

  assign ctrl   = exe.Ctrl;
  assign in1    = ctrl.SelPcQ102H  ? exe.PcQ102H        : exe.RegRdData1Q102H;
  assign in2    = ctrl.SelImmQ102H ? exe.ImmediateQ102H : exe.RegRdData2Q102H;
  assign shamt  = in2[4:0];
  assign md_req = ctrl.ValidQ102H & ctrl.MulDivEnQ102H;

  generate
    if (MULDIV_EN) begin : g_muldiv
      mini_core_muldiv u_muldiv (
        .Clock  (Clock),
        .Rst    (Rst),
        .start  (md_req),
        .flush  (exe.FlushQ102H),
        .op     (ctrl.MulDivOpQ102H),
        .a      (exe.RegRdData1Q102H),
        .b      (exe.RegRdData2Q102H),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
      );
    end else begin : g_no_muldiv
      assign md_busy   = 1'b0;
      assign md_done   = 1'b0;
      assign md_result = 32'd0;
    end
  endgenerate

  assign ready = ~md_busy;

  // Single-cycle ALU
  always_comb begin
    alu_out = 32'd0;
    case (ctrl.AluOpQ102H)
      ALU_ADD:  alu_out = in1 + in2;
      ALU_SUB:  alu_out = in1 - in2;
      ALU_SLL:  alu_out = in1 << shamt;
      ALU_SLT:  alu_out = {31'd0, ($signed(in1) < $signed(in2))};
      ALU_SLTU: alu_out = {31'd0, (in1 < in2)};
      ALU_XOR:  alu_out = in1 ^ in2;
      ALU_SRL:  alu_out = in1 >> shamt;
      ALU_SRA:  alu_out = $unsigned($signed(in1) >>> shamt);
      ALU_OR:   alu_out = in1 | in2;
      ALU_AND:  alu_out = in1 & in2;
      ALU_IN2:  alu_out = in2;
      default:  alu_out = 32'd0;
    endcase
  end

  // M ops only produce a value in the DONE cycle; without the unit they write 0
  always_comb begin
    exe_result = alu_out;
    if (ctrl.MulDivEnQ102H) exe_result = md_done ? md_result : 32'd0;
  end

  // Q103H pipeline registers load every cycle; bubbles on stall or flush
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      valid_q   <= 1'b0;
      alu_out_q <= 32'd0;
      rs2_q     <= 32'd0;
      pc_q      <= 32'd0;
    end else begin
      valid_q   <= ctrl.ValidQ102H & ready & ~exe.FlushQ102H;
      alu_out_q <= exe_result;
      rs2_q     <= exe.RegRdData2Q102H;
      pc_q      <= exe.PcQ102H;
    end
  end

  assign exe.ReadyQ102H      = ready;
  assign exe.ValidQ103H      = valid_q;
  assign exe.AluOutQ103H     = alu_out_q;
  assign exe.RegRdData2Q103H = rs2_q;
  assign exe.PcQ103H         = pc_q;

endmodule

// File: tb/tb_mini_core_exe.sv
// Directed self-checking bench for mini_core_exe.
module tb_mini_core_exe;
  import mini_core_pkg::*;

  logic Clock;
  logic Rst;
  int   test_count = 0;
  int   fail_count = 0;

  mini_core_exe_if exeIf ();

  mini_core_exe #(.MULDIV_EN(1'b1)) dut (
    .Clock (Clock),
    .Rst   (Rst),
    .exe   (exeIf)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic md_en, input t_alu_op alu_op,
                               input t_muldiv_op md_op, input logic sel_pc, input logic sel_imm,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic [31:0] rs1, input logic [31:0] rs2, input logic flush);
    t_ctrl_exe c;
    c.ValidQ102H    = valid;
    c.AluOpQ102H    = alu_op;
    c.SelImmQ102H   = sel_imm;
    c.SelPcQ102H    = sel_pc;
    c.MulDivEnQ102H = md_en;
    c.MulDivOpQ102H = md_op;
    exeIf.Ctrl            = c;
    exeIf.FlushQ102H      = flush;
    exeIf.PcQ102H         = pc;
    exeIf.ImmediateQ102H  = imm;
    exeIf.RegRdData1Q102H = rs1;
    exeIf.RegRdData2Q102H = rs2;
  endtask

  task automatic driveIdle();
    applyStimulus(1'b0, 1'b0, ALU_ADD, MD_MUL, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic driveAlu(input t_alu_op op, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(1'b1, 1'b0, op, MD_MUL, 1'b0, 1'b0, 32'd0, 32'd0, a, b, 1'b0);
  endtask

  task automatic driveMd(input t_muldiv_op op, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(1'b1, 1'b1, ALU_ADD, op, 1'b0, 1'b0, 32'd0, 32'd0, a, b, 1'b0);
  endtask

  // Issues an M op just after a negedge, waits out the stall and checks the result.
  // Returns just after the negedge where the result is visible; the op stays driven.
  task automatic runMd(input string tag, input t_muldiv_op op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expected);
    int low_count;
    int stall_valid;
    driveMd(op, a, b);
    #1;
    low_count   = 0;
    stall_valid = 0;
    while (!exeIf.ReadyQ102H && low_count < 100) begin
      low_count++;
      @(negedge Clock);
      #1;
      if (exeIf.ValidQ103H) stall_valid++;
    end
    checkOutput({tag, "_lat"}, 32'(low_count), 32'd33);
    checkOutput({tag, "_stallvalid"}, 32'(stall_valid), 32'd0);
    @(negedge Clock);
    #1;
    checkOutput({tag, "_valid"}, {31'd0, exeIf.ValidQ103H}, 32'd1);
    checkOutput({tag, "_res"}, exeIf.AluOutQ103H, expected);
  endtask

  t_alu_op    alu_ops [10];
  logic [31:0] alu_a  [10];
  logic [31:0] alu_b  [10];
  logic [31:0] alu_exp[10];

  t_muldiv_op md_ops [13];
  logic [31:0] md_a  [13];
  logic [31:0] md_b  [13];
  logic [31:0] md_exp[13];

  initial begin
    int pulses;
    int low_seen;

    alu_ops[0] = ALU_ADD;  alu_a[0] = 32'h7FFF_FFFF; alu_b[0] = 32'h0000_0001; alu_exp[0] = 32'h8000_0000;
    alu_ops[1] = ALU_SRA;  alu_a[1] = 32'h8000_0000; alu_b[1] = 32'h0000_0004; alu_exp[1] = 32'hF800_0000;
    alu_ops[2] = ALU_SUB;  alu_a[2] = 32'h0000_0000; alu_b[2] = 32'h0000_0001; alu_exp[2] = 32'hFFFF_FFFF;
    alu_ops[3] = ALU_SLT;  alu_a[3] = 32'hFFFF_FFFF; alu_b[3] = 32'h0000_0001; alu_exp[3] = 32'h0000_0001;
    alu_ops[4] = ALU_SLTU; alu_a[4] = 32'hFFFF_FFFF; alu_b[4] = 32'h0000_0001; alu_exp[4] = 32'h0000_0000;
    alu_ops[5] = ALU_SRL;  alu_a[5] = 32'h8000_0000; alu_b[5] = 32'h0000_0024; alu_exp[5] = 32'h0800_0000;
    alu_ops[6] = ALU_SLL;  alu_a[6] = 32'h0000_0001; alu_b[6] = 32'h0000_001F; alu_exp[6] = 32'h8000_0000;
    alu_ops[7] = ALU_XOR;  alu_a[7] = 32'hF0F0_F0F0; alu_b[7] = 32'hFF00_FF00; alu_exp[7] = 32'h0FF0_0FF0;
    alu_ops[8] = ALU_AND;  alu_a[8] = 32'hF0F0_F0F0; alu_b[8] = 32'hFF00_FF00; alu_exp[8] = 32'hF000_F000;
    alu_ops[9] = ALU_IN2;  alu_a[9] = 32'h0000_0000; alu_b[9] = 32'h1234_5678; alu_exp[9] = 32'h1234_5678;

    md_ops[0]  = MD_MULH;   md_a[0]  = 32'hFFFF_FFFE; md_b[0]  = 32'h0000_0003; md_exp[0]  = 32'hFFFF_FFFF;
    md_ops[1]  = MD_MULHU;  md_a[1]  = 32'hFFFF_FFFF; md_b[1]  = 32'hFFFF_FFFF; md_exp[1]  = 32'hFFFF_FFFE;
    md_ops[2]  = MD_MUL;    md_a[2]  = 32'hFFFF_FFFE; md_b[2]  = 32'h0000_0003; md_exp[2]  = 32'hFFFF_FFFA;
    md_ops[3]  = MD_MULHSU; md_a[3]  = 32'hFFFF_FFFF; md_b[3]  = 32'hFFFF_FFFF; md_exp[3]  = 32'hFFFF_FFFF;
    md_ops[4]  = MD_DIV;    md_a[4]  = 32'hFFFF_FFF9; md_b[4]  = 32'h0000_0002; md_exp[4]  = 32'hFFFF_FFFD;
    md_ops[5]  = MD_REM;    md_a[5]  = 32'hFFFF_FFF9; md_b[5]  = 32'h0000_0002; md_exp[5]  = 32'hFFFF_FFFF;
    md_ops[6]  = MD_DIV;    md_a[6]  = 32'h0000_0007; md_b[6]  = 32'h0000_0000; md_exp[6]  = 32'hFFFF_FFFF;
    md_ops[7]  = MD_REM;    md_a[7]  = 32'h0000_0007; md_b[7]  = 32'h0000_0000; md_exp[7]  = 32'h0000_0007;
    md_ops[8]  = MD_DIV;    md_a[8]  = 32'h8000_0000; md_b[8]  = 32'hFFFF_FFFF; md_exp[8]  = 32'h8000_0000;
    md_ops[9]  = MD_REM;    md_a[9]  = 32'h8000_0000; md_b[9]  = 32'hFFFF_FFFF; md_exp[9]  = 32'h0000_0000;
    md_ops[10] = MD_DIVU;   md_a[10] = 32'hFFFF_FFFE; md_b[10] = 32'h0000_0003; md_exp[10] = 32'h5555_5554;
    md_ops[11] = MD_REMU;   md_a[11] = 32'hFFFF_FFFE; md_b[11] = 32'h0000_0003; md_exp[11] = 32'h0000_0002;
    md_ops[12] = MD_REM;    md_a[12] = 32'hFFFF_FFF9; md_b[12] = 32'h0000_0000; md_exp[12] = 32'hFFFF_FFF9;

    // Reset state
    Rst = 1'b0;
    driveIdle();
    repeat (2) @(negedge Clock);
    #1;
    checkOutput("rst_valid", {31'd0, exeIf.ValidQ103H}, 32'd0);
    checkOutput("rst_aluout", exeIf.AluOutQ103H, 32'd0);
    checkOutput("rst_pc", exeIf.PcQ103H, 32'd0);
    checkOutput("rst_rs2", exeIf.RegRdData2Q103H, 32'd0);
    checkOutput("rst_ready", {31'd0, exeIf.ReadyQ102H}, 32'd1);
    Rst = 1'b1;
    @(negedge Clock);
    #1;

    // Back-to-back ALU vectors, one result per cycle
    for (int i = 0; i < 10; i++) begin
      driveAlu(alu_ops[i], alu_a[i], alu_b[i]);
      #1;
      checkOutput($sformatf("alu%0d_ready", i), {31'd0, exeIf.ReadyQ102H}, 32'd1);
      @(negedge Clock);
      #1;
      checkOutput($sformatf("alu%0d_valid", i), {31'd0, exeIf.ValidQ103H}, 32'd1);
      checkOutput($sformatf("alu%0d_res", i), exeIf.AluOutQ103H, alu_exp[i]);
    end

    // PC/immediate operand selection and forwarding
    applyStimulus(1'b1, 1'b0, ALU_ADD, MD_MUL, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_0010,
                  32'hAAAA_AAAA, 32'hDEAD_BEEF, 1'b0);
    @(negedge Clock);
    #1;
    checkOutput("pcimm_res", exeIf.AluOutQ103H, 32'h0000_1010);
    checkOutput("pcimm_pc", exeIf.PcQ103H, 32'h0000_1000);
    checkOutput("pcimm_rs2", exeIf.RegRdData2Q103H, 32'hDEAD_BEEF);

    // Flushed ALU op leaves a bubble
    applyStimulus(1'b1, 1'b0, ALU_ADD, MD_MUL, 1'b0, 1'b0, 32'd0, 32'd0, 32'd1, 32'd2, 1'b1);
    @(negedge Clock);
    #1;
    checkOutput("aluflush_valid", {31'd0, exeIf.ValidQ103H}, 32'd0);
    driveIdle();
    @(negedge Clock);
    #1;

    // Isolated M ops, each followed by an idle cycle to confirm a single pulse
    for (int i = 0; i < 13; i++) begin
      runMd($sformatf("md%0d", i), md_ops[i], md_a[i], md_b[i], md_exp[i]);
      driveIdle();
      @(negedge Clock);
      #1;
      checkOutput($sformatf("md%0d_pulse", i), {31'd0, exeIf.ValidQ103H}, 32'd0);
    end

    // MUL, DIV, ADD back-to-back
    runMd("b2b_mul", MD_MUL, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A);
    runMd("b2b_div", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    driveAlu(ALU_ADD, 32'd5, 32'd6);
    @(negedge Clock);
    #1;
    checkOutput("b2b_add_valid", {31'd0, exeIf.ValidQ103H}, 32'd1);
    checkOutput("b2b_add_res", exeIf.AluOutQ103H, 32'h0000_000B);
    driveIdle();
    @(negedge Clock);
    #1;
    checkOutput("b2b_tail_valid", {31'd0, exeIf.ValidQ103H}, 32'd0);

    // Flush during BUSY iteration 10
    driveMd(MD_DIV, 32'd100, 32'd7);
    repeat (10) @(negedge Clock);
    exeIf.FlushQ102H = 1'b1;
    #1;
    checkOutput("flush_busy_ready", {31'd0, exeIf.ReadyQ102H}, 32'd0);
    @(negedge Clock);
    driveIdle();
    #1;
    checkOutput("flush_ready", {31'd0, exeIf.ReadyQ102H}, 32'd1);
    checkOutput("flush_valid", {31'd0, exeIf.ValidQ103H}, 32'd0);
    pulses   = 0;
    low_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      #1;
      if (exeIf.ValidQ103H) pulses++;
      if (!exeIf.ReadyQ102H) low_seen++;
    end
    checkOutput("flush_no_result", 32'(pulses), 32'd0);
    checkOutput("flush_no_stall", 32'(low_seen), 32'd0);

    // Reset in the middle of a divide
    applyStimulus(1'b1, 1'b1, ALU_ADD, MD_DIV, 1'b0, 1'b0, 32'h4444_0000, 32'd0,
                  32'd100, 32'h0000_0007, 1'b0);
    repeat (5) @(negedge Clock);
    #1;
    checkOutput("midrst_pc_before", exeIf.PcQ103H, 32'h4444_0000);
    Rst = 1'b0;
    @(negedge Clock);
    #1;
    checkOutput("midrst_valid", {31'd0, exeIf.ValidQ103H}, 32'd0);
    checkOutput("midrst_aluout", exeIf.AluOutQ103H, 32'd0);
    checkOutput("midrst_pc", exeIf.PcQ103H, 32'd0);
    checkOutput("midrst_rs2", exeIf.RegRdData2Q103H, 32'd0);
    checkOutput("midrst_ready", {31'd0, exeIf.ReadyQ102H}, 32'd1);
    driveIdle();
    Rst = 1'b1;
    @(negedge Clock);
    #1;
    driveAlu(ALU_OR, 32'h0000_00F0, 32'h0000_000F);
    @(negedge Clock);
    #1;
    checkOutput("postrst_res", exeIf.AluOutQ103H, 32'h0000_00FF);
    checkOutput("postrst_valid", {31'd0, exeIf.ValidQ103H}, 32'd1);
    driveIdle();
    @(negedge Clock);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
